// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage pipelined Hack ALU with valid/ready handshakes.
// Stage 1 captures operands and controls; stage 2 computes and holds the
// result with its zr/ng flags until the consumer takes it.
module hack_alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    localparam int unsigned CTL_W = 6;

    // control vector layout: {zx, nx, zy, ny, f, no}
    localparam int unsigned C_ZX = 5;
    localparam int unsigned C_NX = 4;
    localparam int unsigned C_ZY = 3;
    localparam int unsigned C_NY = 2;
    localparam int unsigned C_F  = 1;
    localparam int unsigned C_NO = 0;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;
    logic [CTL_W-1:0] s1_ctl_q, s1_ctl_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;

    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-1:0] xa, xb, ya, yb, r, res;

    // Stall/advance control; in_ready is combinational from out_ready so a
    // full pipe can accept and drain on the same edge.
    always_comb begin
        s2_en    = !s2_valid_q || out_ready;
        s1_en    = !s1_valid_q || s2_en;
        in_ready = s1_en;
    end

    // ALU datapath evaluated on the stage-1 registers.
    always_comb begin
        xa  = s1_ctl_q[C_ZX] ? '0 : s1_x_q;
        xb  = s1_ctl_q[C_NX] ? ~xa : xa;
        ya  = s1_ctl_q[C_ZY] ? '0 : s1_y_q;
        yb  = s1_ctl_q[C_NY] ? ~ya : ya;
        r   = s1_ctl_q[C_F] ? WIDTH'(xb + yb) : (xb & yb);
        res = s1_ctl_q[C_NO] ? ~r : r;
    end

    // Next-state for both stages: load on enable, otherwise hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_ctl_d   = s1_ctl_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        zr_d       = zr_q;
        ng_d       = ng_q;

        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d   = x;
                s1_y_d   = y;
                s1_ctl_d = {zx, nx, zy, ny, f, no};
            end
        end

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = res;
                zr_d  = (res == '0);
                ng_d  = res[WIDTH-1];
            end
        end
    end

    // Pipeline registers; reset discards any beats in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_ctl_q   <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_ctl_q   <= s1_ctl_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            zr_q       <= zr_d;
            ng_q       <= ng_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

endmodule
